// File: rtl/diff_amp_sar_ctrl.sv
// SAR controller for the differential amplifier: sequences track/hold, binary-searches
// the amplified voltage against the ladder DAC and reports the code with a done pulse.
module diff_amp_sar_ctrl #(
  parameter int unsigned WIDTH      = 8,
  parameter int unsigned SAMPLE_CYC = 4,
  parameter int unsigned SETTLE     = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ena,
  input  logic             start,
  input  logic             cmp_in,
  output logic             sample,
  output logic [WIDTH-1:0] dac_code,
  output logic [WIDTH-1:0] result,
  output logic             busy,
  output logic             done
);

  localparam int unsigned IW   = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int unsigned CMAX = (SAMPLE_CYC > SETTLE) ? SAMPLE_CYC : SETTLE;
  localparam int unsigned CW   = (CMAX > 1) ? $clog2(CMAX) : 1;

  typedef enum logic [1:0] {IDLE, SAMPLE, CONV, DONE} state_t;

  state_t           state;
  logic [CW-1:0]    cnt;
  logic [IW-1:0]    bit_idx;
  logic             cmp_meta;
  logic             cmp_s;
  logic [WIDTH-1:0] decided;
  logic [WIDTH-1:0] next_trial;

  // Current trial with its bit resolved, and the following trial code built from it
  always_comb begin
    decided          = dac_code;
    decided[bit_idx] = cmp_s;
    next_trial       = decided | (WIDTH'(1) << (bit_idx - IW'(1)));
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= IDLE;
      cnt      <= '0;
      bit_idx  <= '0;
      cmp_meta <= 1'b0;
      cmp_s    <= 1'b0;
      sample   <= 1'b0;
      dac_code <= '0;
      result   <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      cmp_meta <= cmp_in;
      cmp_s    <= cmp_meta;
      done     <= 1'b0;
      if (!ena) begin
        // Abort: drop back to idle without touching the last good result
        state    <= IDLE;
        cnt      <= '0;
        sample   <= 1'b0;
        busy     <= 1'b0;
        dac_code <= result;
      end else begin
        case (state)
          IDLE: begin
            cnt      <= '0;
            dac_code <= result;
            if (start) begin
              state    <= SAMPLE;
              sample   <= 1'b1;
              busy     <= 1'b1;
              bit_idx  <= IW'(WIDTH - 1);
              dac_code <= WIDTH'(1) << (WIDTH - 1);
            end
          end
          SAMPLE: begin
            if (cnt == CW'(SAMPLE_CYC - 1)) begin
              state  <= CONV;
              sample <= 1'b0;
              cnt    <= '0;
            end else begin
              cnt <= cnt + CW'(1);
            end
          end
          CONV: begin
            if (cnt == CW'(SETTLE - 1)) begin
              cnt <= '0;
              if (bit_idx == '0) begin
                state    <= DONE;
                result   <= decided;
                dac_code <= decided;
                busy     <= 1'b0;
                done     <= 1'b1;
              end else begin
                dac_code <= next_trial;
                bit_idx  <= bit_idx - IW'(1);
              end
            end else begin
              cnt <= cnt + CW'(1);
            end
          end
          DONE: begin
            state <= IDLE;
          end
          default: begin
            state <= IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_diff_amp_sar_ctrl.sv
// Directed bench for diff_amp_sar_ctrl: constant and behavioural comparators,
// back-to-back starts, ignored starts, enable abort and mid-conversion reset.
module tb_diff_amp_sar_ctrl;

  logic       clk;
  logic       rst_n;
  logic       ena;
  logic       start;
  logic       cmp_in;
  logic       sample;
  logic [7:0] dac_code;
  logic [7:0] result;
  logic       busy;
  logic       done;

  logic [1:0] cmp_mode;
  logic [7:0] cmp_target;
  int         checks;
  int         errors;

  diff_amp_sar_ctrl #(.WIDTH(8), .SAMPLE_CYC(4), .SETTLE(4)) dut (
    .clk(clk), .rst_n(rst_n), .ena(ena), .start(start), .cmp_in(cmp_in),
    .sample(sample), .dac_code(dac_code), .result(result), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  // Comparator: constant 0/1, or an ideal compare against a target with 3 ns skew
  always @(dac_code or cmp_mode or cmp_target)
    cmp_in <= #3 (cmp_mode == 2'd2) ? (cmp_target >= dac_code) : cmp_mode[0];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_zero(input string tag);
    check({tag, ".sample"}, 32'(sample), 32'd0);
    check({tag, ".busy"}, 32'(busy), 32'd0);
    check({tag, ".done"}, 32'(done), 32'd0);
    check({tag, ".dac_code"}, 32'(dac_code), 32'd0);
    check({tag, ".result"}, 32'(result), 32'd0);
  endtask

  // Caller has set start=1 at a falling edge; n counts rising edges after E0
  task automatic run_conv(input logic [7:0] t, input bit hold, input bit pulse);
    logic [7:0] exp_trial;
    int         i;
    for (int n = 0; n < 38; n++) begin
      @(negedge clk);
      if (hold) start = 1'b1;
      else if (pulse && ((n >= 10 && n <= 12) || n == 36)) start = 1'b1;
      else start = 1'b0;
      if (n < 4) begin
        check("track.sample", 32'(sample), 32'd1);
        check("track.busy", 32'(busy), 32'd1);
        if (n == 0) check("track.dac_code", 32'(dac_code), 32'h80);
      end else if (n < 36) begin
        if ((n - 4) % 4 == 0) begin
          i = 7 - (n - 4) / 4;
          exp_trial = 8'(((int'(t) >> (i + 1)) << (i + 1)) | (1 << i));
          check($sformatf("trial_bit%0d.dac_code", i), 32'(dac_code), 32'(exp_trial));
          check("conv.sample", 32'(sample), 32'd0);
          check("conv.busy", 32'(busy), 32'd1);
          check("conv.done", 32'(done), 32'd0);
        end
      end else if (n == 36) begin
        check("done.done", 32'(done), 32'd1);
        check("done.busy", 32'(busy), 32'd0);
        check("done.result", 32'(result), 32'(t));
        check("done.dac_code", 32'(dac_code), 32'(t));
      end else begin
        check("post.done", 32'(done), 32'd0);
        check("post.busy", 32'(busy), 32'd0);
        check("post.sample", 32'(sample), 32'd0);
        check("post.dac_code", 32'(dac_code), 32'(t));
      end
    end
  endtask

  initial begin
    clk = 1'b0; rst_n = 1'b0; ena = 1'b1; start = 1'b0;
    cmp_mode = 2'd0; cmp_target = 8'h00; checks = 0; errors = 0;

    repeat (2) @(negedge clk);
    check_zero("reset");
    rst_n = 1'b1;
    @(negedge clk);
    check("idle.busy", 32'(busy), 32'd0);
    check("idle.dac_code", 32'(dac_code), 32'd0);

    // Comparator stuck high, then stuck low
    cmp_mode = 2'd1; start = 1'b1;
    run_conv(8'hFF, 1'b0, 1'b0);
    cmp_mode = 2'd0; start = 1'b1;
    run_conv(8'h00, 1'b0, 1'b0);

    // Start held high: back-to-back conversions on a 38-cycle period
    cmp_mode = 2'd2; cmp_target = 8'hA5; start = 1'b1;
    run_conv(8'hA5, 1'b1, 1'b0);
    run_conv(8'hA5, 1'b0, 1'b0);
    @(negedge clk);
    check("after_hold.busy", 32'(busy), 32'd0);

    // Behavioural comparator with start pulses during CONV and DONE
    cmp_target = 8'h5A; start = 1'b1;
    run_conv(8'h5A, 1'b0, 1'b1);
    repeat (2) begin
      @(negedge clk);
      check("ignored_start.busy", 32'(busy), 32'd0);
      check("ignored_start.done", 32'(done), 32'd0);
    end

    // Enable dropped during the bit-4 trial
    cmp_target = 8'h33; start = 1'b1;
    for (int n = 0; n < 18; n++) begin
      @(negedge clk);
      start = 1'b0;
      if (n == 16) check("abort.trial_bit4", 32'(dac_code), 32'h30);
      if (n == 17) ena = 1'b0;
    end
    @(negedge clk);
    check("abort.busy", 32'(busy), 32'd0);
    check("abort.sample", 32'(sample), 32'd0);
    check("abort.done", 32'(done), 32'd0);
    check("abort.result", 32'(result), 32'h5A);
    check("abort.dac_code", 32'(dac_code), 32'h5A);
    ena = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check("abort_after.done", 32'(done), 32'd0);
      check("abort_after.busy", 32'(busy), 32'd0);
    end
    check("abort_after.result", 32'(result), 32'h5A);

    // Reset pulsed mid-conversion, then a fresh conversion
    cmp_target = 8'hC3; start = 1'b1;
    for (int n = 0; n < 21; n++) begin
      @(negedge clk);
      start = 1'b0;
      if (n == 20) rst_n = 1'b0;
    end
    @(negedge clk);
    check_zero("midconv_reset");
    rst_n = 1'b1; start = 1'b1;
    run_conv(8'hC3, 1'b0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
